mixer_seq: RTL



---
 rtl/mixer_pkg.sv | 25 ++
 rtl/mixer_sat.sv | 58 +++++
 rtl/mixer_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mixer_pkg.sv
// Shared types and helpers for the time-multiplexed audio mixer.
// Holds the FSM state encoding, accumulator sizing and midpoint helper.
package mixer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_OUT
    } state_t;

    // Signed accumulator width that cannot overflow for any input/gain mix.
    function automatic int acc_width(
        input int bitdepth,
        input int gainbits,
        input int channels
    );
        return bitdepth + gainbits + $clog2(channels) + 1;
    endfunction

    // Offset-binary zero level.
    function automatic int midpoint(input int bitdepth);
        return 1 << (bitdepth - 1);
    endfunction

endpackage

// File: rtl/mixer_sat.sv
// Output stage of the mixer: scales the accumulated sum down, limits it
// to the sample range and converts it back to offset-binary.
//
// Ports:
//   acc  : signed accumulated sum of all channel products
//   mix  : offset-binary output sample
//   clip : 1 when the scaled sum had to be limited
//
// Build option MIXER_SEQ_CLIP_EN: when defined the scaled sum saturates
// and clip reports it; otherwise the sum wraps (two's complement) and
// clip is tied low.
module mixer_sat
    import mixer_pkg::*;
#(
    parameter int BITDEPTH = 14,
    parameter int GAINBITS = 8,
    parameter int HEADROOM = 1,
    parameter int AW       = 26
) (
    input  logic signed [AW-1:0]       acc,
    output logic        [BITDEPTH-1:0] mix,
    output logic                       clip
);

    localparam int SH = GAINBITS + HEADROOM;
    localparam logic [BITDEPTH-1:0] MID = BITDEPTH'(midpoint(BITDEPTH));

    logic signed [AW-1:0] s;

    // Arithmetic shift floors toward minus infinity.
    assign s = acc >>> SH;

`ifdef MIXER_SEQ_CLIP_EN
    localparam logic signed [AW-1:0] SMAX = AW'(midpoint(BITDEPTH) - 1);
    // ~x equals -x-1 in two's complement, i.e. the most negative sample.
    localparam logic signed [AW-1:0] SMIN = ~SMAX;

    logic signed [AW-1:0] sv;

    always_comb begin
        sv   = s;
        clip = 1'b0;
        if (s > SMAX) begin
            sv   = SMAX;
            clip = 1'b1;
        end else if (s < SMIN) begin
            sv   = SMIN;
            clip = 1'b1;
        end
        mix = BITDEPTH'(sv + AW'(MID));
    end
`else
    // Truncation after the offset add equals wrapping s then adding MID.
    assign mix  = BITDEPTH'(s + AW'(MID));
    assign clip = 1'b0;
`endif

endmodule

// File: rtl/mixer_seq.sv
// Time-multiplexed N-channel audio mixer: one multiply-accumulate per clk
// after each rising edge of sample_clock, then one scaled output sample.
//
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   sample_clock : frame request level, rising edge starts a frame
//   in_flat      : CHANNELS offset-binary samples, ch k at [k*BITDEPTH +:]
//   gain_flat    : CHANNELS unsigned gains, ch k at [k*GAINBITS +:]
//   mute         : per-channel mute, 1 = channel contributes zero
//   mix          : registered offset-binary mixed sample
//   mix_valid    : one-cycle pulse when mix updates
//   clip         : saturation flag, valid with mix_valid
//   overrun      : sticky, frame requested while busy
//
// Build option MIXER_SEQ_CLIP_EN selects saturation (see mixer_sat).
module mixer_seq
    import mixer_pkg::*;
#(
    parameter int BITDEPTH = 14,
    parameter int CHANNELS = 8,
    parameter int GAINBITS = 8,
    parameter int HEADROOM = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_clock,
    input  logic [CHANNELS*BITDEPTH-1:0] in_flat,
    input  logic [CHANNELS*GAINBITS-1:0] gain_flat,
    input  logic [CHANNELS-1:0]          mute,
    output logic [BITDEPTH-1:0]          mix,
    output logic                         mix_valid,
    output logic                         clip,
    output logic                         overrun
);

    localparam int AW = acc_width(BITDEPTH, GAINBITS, CHANNELS);
    localparam int CW = $clog2(CHANNELS);
    localparam int PW = BITDEPTH + GAINBITS + 2;
    localparam logic [BITDEPTH-1:0] MID = BITDEPTH'(midpoint(BITDEPTH));

    state_t state;
    state_t state_next;

    logic sc_q;
    logic start;

    logic [CHANNELS*BITDEPTH-1:0] in_q;
    logic [CHANNELS*GAINBITS-1:0] gain_q;
    logic [CHANNELS-1:0]          mute_q;

    logic        [CW-1:0]       ch;
    logic                       last_ch;
    logic signed [AW-1:0]       acc;
    logic        [BITDEPTH-1:0] in_k;
    logic        [GAINBITS-1:0] gain_k;
    logic signed [BITDEPTH:0]   diff;
    logic signed [PW-1:0]       prod;
    logic signed [AW-1:0]       term;

    logic [BITDEPTH-1:0] sat_mix;
    logic                sat_clip;

    assign start   = sample_clock & ~sc_q;
    assign last_ch = (ch == CW'(CHANNELS - 1));

    // Datapath for the channel selected by the counter, from the snapshot.
    assign in_k   = in_q[ch*BITDEPTH +: BITDEPTH];
    assign gain_k = gain_q[ch*GAINBITS +: GAINBITS];
    assign diff   = $signed({1'b0, in_k}) - $signed({1'b0, MID});
    assign prod   = PW'(diff) * PW'($signed({1'b0, gain_k}));
    assign term   = mute_q[ch] ? '0 : AW'(prod);

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start) state_next = ST_ACCUM;
            ST_ACCUM: if (last_ch) state_next = ST_OUT;
            ST_OUT:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_q      <= 1'b0;
            in_q      <= '0;
            gain_q    <= '0;
            mute_q    <= '0;
            ch        <= '0;
            acc       <= '0;
            mix       <= MID;
            mix_valid <= 1'b0;
            clip      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sc_q      <= sample_clock;
            mix_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        in_q   <= in_flat;
                        gain_q <= gain_flat;
                        mute_q <= mute;
                        ch     <= '0;
                        acc    <= '0;
                    end
                end
                ST_ACCUM: begin
                    acc <= acc + term;
                    ch  <= ch + CW'(1);
                end
                ST_OUT: begin
                    mix       <= sat_mix;
                    clip      <= sat_clip;
                    mix_valid <= 1'b1;
                end
                default: ;
            endcase
            // A request while busy is dropped; the running frame is untouched.
            if (start && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

    mixer_sat #(
        .BITDEPTH (BITDEPTH),
        .GAINBITS (GAINBITS),
        .HEADROOM (HEADROOM),
        .AW       (AW)
    ) u_sat (
        .acc  (acc),
        .mix  (sat_mix),
        .clip (sat_clip)
    );

endmodule
